// File: rtl/mul_acc_pkg.sv
// Shared widths and FSM state encoding for the multiply-accumulate output stage.
package mul_acc_pkg;

  localparam int unsigned ACC_W_DEF = 40;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned PROD_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// ACC_W-bit accumulate add with carry-out; clamps to all-ones when MUL_ACC_SAT_EN is defined.
module acc_sat_add
  import mul_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_add,
  output logic [ACC_W-1:0]  o_sum_c,
  output logic              o_carry_c
);

  logic [ACC_W:0] w_full;

  assign w_full    = {1'b0, i_acc} + (ACC_W+1)'(i_add);
  assign o_carry_c = w_full[ACC_W];

`ifdef MUL_ACC_SAT_EN
  // Once clamped, any nonzero add carries again, so the value holds at all-ones.
  assign o_sum_c = o_carry_c ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum_c = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul_acc_stage.sv
// Dot-product accumulate stage: sums products per group and presents the result with a valid/ready handshake.
// Build option: define MUL_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module mul_acc_stage
  import mul_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_acc;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic               w_in_fire;
  logic               w_out_fire;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ovf_nxt;

  // Only path from an input to an output: ready passes through while a result waits.
  assign in_ready   = (r_state != ST_HOLD) || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_acc     (r_acc),
    .i_add     (in_prod),
    .o_sum_c   (w_sum),
    .o_carry_c (w_carry)
  );

  assign w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_ovf_nxt = r_ovf | w_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_in_fire) begin
          w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (w_out_fire) begin
          if (w_in_fire) begin
            w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Group accumulator clears on the last transfer so the next product opens a fresh group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_in_fire) begin
      if (in_last) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  // Result registers load only on a last transfer, so they hold while backpressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == ST_HOLD);
      if (w_in_fire && in_last) begin
        r_out_acc   <= w_sum;
        r_out_count <= w_cnt_nxt;
        r_out_ovf   <= w_ovf_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Directed self-checking bench for mul_acc_stage; expected values are hand-computed.
module tb_mul_acc_stage;

  localparam int unsigned ACC_W = 40;
  localparam int unsigned CNT_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  int n_total;
  int n_bad;

  mul_acc_stage #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One input beat; inputs change 1 time unit after the edge, outputs sampled there too.
  task automatic send(input logic [31:0] prod, input logic last);
    in_valid = 1'b1;
    in_prod  = prod;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_ovf_acc;

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef MUL_ACC_SAT_EN
    exp_ovf_acc = 64'h00_0000_00FF_FFFF_FFFF;
`else
    exp_ovf_acc = 64'h00_0000_0000_FFFF_FEFF;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_acc",   64'(out_acc),   64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_ovf",   64'(out_ovf),   64'd0);
    rst_n = 1'b1;
    idle_cycle();

    // 3 + 5 + 7
    send(32'd3, 1'b0);
    check("grp1_mid_valid", 64'(out_valid), 64'd0);
    send(32'd5, 1'b0);
    send(32'd7, 1'b1);
    check("grp1_valid", 64'(out_valid), 64'd1);
    check("grp1_acc",   64'(out_acc),   64'd15);
    check("grp1_count", 64'(out_count), 64'd3);
    check("grp1_ovf",   64'(out_ovf),   64'd0);
    idle_cycle();
    check("grp1_consumed", 64'(out_valid), 64'd0);

    // Single large product
    send(32'hFFFE_0001, 1'b1);
    check("single_acc",   64'(out_acc),   64'h00_FFFE_0001);
    check("single_count", 64'(out_count), 64'd1);
    idle_cycle();

    // Backpressure with a simultaneous consume-and-accept
    out_ready = 1'b0;
    send(32'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      check("bp_in_ready", 64'(in_ready),  64'd0);
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_acc",      64'(out_acc),   64'd4);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_prod   = 32'd2;
    in_last   = 1'b1;
    #1;
    check("bp_ready_pass", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_acc",   64'(out_acc),   64'd2);
    check("bp_next_count", 64'(out_count), 64'd1);
    idle_cycle();

    // HOLD -> ACCUM: consume while accepting a non-last term
    out_ready = 1'b0;
    send(32'd100, 1'b1);
    out_ready = 1'b1;
    send(32'd5, 1'b0);
    check("h2a_valid", 64'(out_valid), 64'd0);
    send(32'd6, 1'b1);
    check("h2a_acc",   64'(out_acc),   64'd11);
    check("h2a_count", 64'(out_count), 64'd2);
    idle_cycle();

    // Zero products count as terms
    send(32'd0, 1'b0);
    send(32'd0, 1'b1);
    check("zero_acc",   64'(out_acc),   64'd0);
    check("zero_count", 64'(out_count), 64'd2);
    check("zero_valid", 64'(out_valid), 64'd1);
    idle_cycle();

    // Overflow: 257 x 0xFFFFFFFF
    for (int i = 0; i < 256; i++) send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    check("ovf_count", 64'(out_count), 64'd255);
    check("ovf_flag",  64'(out_ovf),   64'd1);
    check("ovf_acc",   64'(out_acc),   exp_ovf_acc);
    idle_cycle();

    // Next group after overflow starts clean
    send(32'd1, 1'b1);
    check("post_ovf_acc",   64'(out_acc),   64'd1);
    check("post_ovf_flag",  64'(out_ovf),   64'd0);
    check("post_ovf_count", 64'(out_count), 64'd1);
    idle_cycle();

    // Reset mid-group discards the partial sum
    send(32'd11, 1'b0);
    send(32'd12, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_acc",   64'(out_acc),   64'd0);
    rst_n = 1'b1;
    idle_cycle();
    send(32'd9, 1'b1);
    check("midrst_new_acc",   64'(out_acc),   64'd9);
    check("midrst_new_count", 64'(out_count), 64'd1);
    idle_cycle();

    // Reset while a result is pending drops it
    out_ready = 1'b0;
    send(32'd21, 1'b1);
    rst_n = 1'b0;
    #2;
    check("holdrst_valid", 64'(out_valid), 64'd0);
    check("holdrst_ready", 64'(in_ready),  64'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle_cycle();
    check("holdrst_stays", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
